// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and helpers for the instruction-fetch front end.
// Used by ifetch_queue and ifetch_prefetch_buffer (optional IFETCH_BYPASS_EN).
package ifetch_pkg;

  typedef enum logic [1:0] {
    FS_WAIT,
    FS_REQ,
    FS_DROP
  } fetch_state_t;

  localparam int unsigned BYTE_BITS = 8;

  function automatic int unsigned byte_inc(
    input int unsigned data_w
  );
    return data_w / BYTE_BITS;
  endfunction

endpackage

// File: rtl/ifetch_queue.sv
// ifetch_queue: DEPTH-entry FIFO of {pc, word} pairs for the prefetcher.
// Flush wins over push and pop; simultaneous push+pop is supported.
import ifetch_pkg::*;

module ifetch_queue #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [ADDR_W-1:0]        push_pc,
  input  logic [DATA_W-1:0]        push_word,
  input  logic                     pop,
  output logic                     head_valid,
  output logic [ADDR_W-1:0]        head_pc,
  output logic [DATA_W-1:0]        head_word,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] word_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              pop_ok;
  logic              wr_en;

  assign head_valid = (count != '0);
  assign head_pc    = pc_mem[rd_ptr];
  assign head_word  = word_mem[rd_ptr];
  assign pop_ok     = pop && head_valid;
  assign wr_en      = push && !flush && !reset;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_ptr]   <= push_pc;
      word_mem[wr_ptr] <= push_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop_ok);
    end
  end

  // The fetch FSM only issues with room; a push into a full queue is a bug.
  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      assert (!(push && !pop_ok && count == CNT_W'(DEPTH)));
    end
  end

endmodule

// File: rtl/ifetch_prefetch_buffer.sv
// ifetch_prefetch_buffer: sequential prefetcher with redirect/flush handling.
// Define IFETCH_BYPASS_EN for a zero-latency memory-to-decode path.
import ifetch_pkg::*;

module ifetch_prefetch_buffer #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instruction,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] memory_addr,
  output logic              memory_rden,
  input  logic [DATA_W-1:0] memory_read_val,
  input  logic              memory_response
);

  localparam int                CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] INC   = ADDR_W'(byte_inc(DATA_W));

  fetch_state_t      state;
  logic [ADDR_W-1:0] redir_pc;
  logic              q_valid;
  logic [ADDR_W-1:0] q_pc;
  logic [DATA_W-1:0] q_word;
  logic [CNT_W-1:0]  q_count;
  logic [CNT_W-1:0]  cnt_after;
  logic              complete;
  logic              push;
  logic              pop;
  logic              bypass_take;

  assign complete = memory_rden && memory_response;

`ifdef IFETCH_BYPASS_EN
  logic bypass;

  assign bypass = !q_valid && state == FS_REQ &&
                  memory_response && !redirect_valid;
  assign instr_valid = (q_valid || bypass) && !redirect_valid;
  assign instruction = q_valid ? q_word :
                       bypass  ? memory_read_val : '0;
  assign instr_pc    = q_valid ? q_pc :
                       bypass  ? memory_addr : '0;
  assign bypass_take = bypass && instr_ready;
`else
  assign instr_valid = q_valid && !redirect_valid;
  assign instruction = q_valid ? q_word : '0;
  assign instr_pc    = q_valid ? q_pc : '0;
  assign bypass_take = 1'b0;
`endif

  assign pop  = q_valid && instr_valid && instr_ready;
  assign push = complete && state == FS_REQ &&
                !redirect_valid && !bypass_take;
  assign cnt_after = q_count + CNT_W'(push) - CNT_W'(pop);

  ifetch_queue #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (push),
    .push_pc    (memory_addr),
    .push_word  (memory_read_val),
    .pop        (pop),
    .head_valid (q_valid),
    .head_pc    (q_pc),
    .head_word  (q_word),
    .count      (q_count)
  );

  // memory_addr doubles as the next fetch pc; during FS_DROP it must
  // hold the stale address, so the redirect target waits in redir_pc.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FS_WAIT;
      memory_rden <= 1'b0;
      memory_addr <= RESET_PC;
      redir_pc    <= RESET_PC;
    end else begin
      unique case (state)
        FS_WAIT: begin
          if (redirect_valid) begin
            memory_addr <= redirect_pc;
            memory_rden <= 1'b1;
            state       <= FS_REQ;
          end else if (cnt_after < FULL) begin
            memory_rden <= 1'b1;
            state       <= FS_REQ;
          end
        end
        FS_REQ: begin
          if (redirect_valid && complete) begin
            memory_addr <= redirect_pc;
          end else if (redirect_valid) begin
            redir_pc <= redirect_pc;
            state    <= FS_DROP;
          end else if (complete) begin
            memory_addr <= memory_addr + INC;
            if (cnt_after >= FULL) begin
              memory_rden <= 1'b0;
              state       <= FS_WAIT;
            end
          end
        end
        FS_DROP: begin
          if (complete) begin
            memory_addr <= redirect_valid ? redirect_pc : redir_pc;
            state       <= FS_REQ;
          end else if (redirect_valid) begin
            redir_pc <= redirect_pc;
          end
        end
        default: begin
          memory_rden <= 1'b0;
          state       <= FS_WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_prefetch_buffer.sv
// tb_ifetch_prefetch_buffer: directed bench with a memory model
// and an expected-pc scoreboard for ifetch_prefetch_buffer.
module tb_ifetch_prefetch_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic [31:0] memory_addr;
  logic        memory_rden;
  logic [31:0] memory_read_val = '0;
  logic        memory_response = 1'b0;

  int tests = 0;
  int fails = 0;

  int lat = 1;
  bit stray = 1'b0;
  int n_done = 0;

  logic [31:0] sb[$];
  bit gap_en = 1'b0;
  int gaps = 0;
  int cyc = 0;
  int last_cyc = -1;

  always #5 clk = ~clk;

  ifetch_prefetch_buffer #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instruction     (instruction),
    .instr_pc        (instr_pc),
    .memory_addr     (memory_addr),
    .memory_rden     (memory_rden),
    .memory_read_val (memory_read_val),
    .memory_response (memory_response)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #2;
  endtask

  // Memory: responds once a request has been up for lat cycles.
  initial begin
    int age;
    bit prev;
    age = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (prev) n_done++;
      if (memory_rden) age = prev ? 1 : age + 1;
      else age = 0;
      memory_response = stray || (memory_rden && age >= lat);
      memory_read_val = word_of(memory_addr);
      prev = memory_rden && memory_response;
    end
  end

  // Scoreboard consumer: every accepted instruction pops one expected pc.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (instr_valid && instr_ready && sb.size() > 0) begin
        e = sb.pop_front();
        check("pc", instr_pc, e);
        check("word", instruction, word_of(e));
        if (gap_en && last_cyc >= 0 && cyc - last_cyc != 1) gaps++;
        last_cyc = cyc;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int t;

    // reset state
    repeat (3) step();
    sample();
    check("rst_rden", 32'(memory_rden), 32'd0);
    check("rst_addr", memory_addr, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instruction, 32'h0);
    check("rst_pc", instr_pc, 32'h0);
    step();
    reset = 1'b0;
    sample();
    check("rden_pre", 32'(memory_rden), 32'd0);
    sample();
    check("rden_rise", 32'(memory_rden), 32'd1);
    check("addr0", memory_addr, 32'h0);

    // decode stalled: queue fills with exactly DEPTH words
    repeat (10) sample();
    check("pushes", n_done, 32'd4);
    check("rden_full", 32'(memory_rden), 32'd0);
    check("valid_full", 32'(instr_valid), 32'd1);
    check("head_full", instr_pc, 32'h0);

    for (int i = 0; i < 16; i++) sb.push_back(32'(i * 4));
    step();
    instr_ready = 1'b1;
    gap_en = 1'b1;
    sample();
    check("rden_held", 32'(memory_rden), 32'd0);
    sample();
    check("rden_re", 32'(memory_rden), 32'd1);
    check("addr_re", memory_addr, 32'h10);
    for (t = 0; t < 100 && sb.size() > 0; t++) sample();
    check("drain1", 32'(t < 100), 32'd1);
    check("gaps", gaps, 32'd0);
    gap_en = 1'b0;

    // redirect while the request to 0x8 is outstanding
    step();
    reset = 1'b1;
    instr_ready = 1'b0;
    lat = 4;
    sb.delete();
    step();
    step();
    reset = 1'b0;
    instr_ready = 1'b1;
    sb.push_back(32'h0);
    sb.push_back(32'h4);
    for (t = 0; t < 100 && !(memory_rden && memory_addr == 32'h8); t++)
      sample();
    check("reach8", 32'(t < 100), 32'd1);
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    sb.delete();
    sb.push_back(32'h100);
    sb.push_back(32'h104);
    sb.push_back(32'h108);
    step();
    redirect_valid = 1'b0;
    sample();
    check("drop_addr", memory_addr, 32'h8);
    check("drop_rden", 32'(memory_rden), 32'd1);
    check("drop_valid", 32'(instr_valid), 32'd0);
    for (t = 0; t < 100 && memory_addr != 32'h100; t++) sample();
    check("redir_addr", memory_addr, 32'h100);
    check("redir_rden", 32'(memory_rden), 32'd1);
    for (t = 0; t < 100 && sb.size() > 0; t++) sample();
    check("drain2", 32'(t < 100), 32'd1);

    // redirect in the same cycle as a completion
    for (t = 0; t < 100 && !memory_response; t++) sample();
    check("resp_seen", 32'(t < 100), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    sb.delete();
    sb.push_back(32'h200);
    sb.push_back(32'h204);
    step();
    redirect_valid = 1'b0;
    sample();
    check("coin_addr", memory_addr, 32'h200);
    check("coin_rden", 32'(memory_rden), 32'd1);
    check("coin_valid", 32'(instr_valid), 32'd0);
    for (t = 0; t < 100 && sb.size() > 0; t++) sample();
    check("drain3", 32'(t < 100), 32'd1);

    // address wrap at the top of the space
    step();
    lat = 1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    sb.delete();
    sb.push_back(32'hFFFF_FFF8);
    sb.push_back(32'hFFFF_FFFC);
    sb.push_back(32'h0);
    sb.push_back(32'h4);
    step();
    redirect_valid = 1'b0;
    for (t = 0; t < 100 && memory_addr != 32'hFFFF_FFFC; t++) sample();
    check("reach_top", memory_addr, 32'hFFFF_FFFC);
    for (t = 0; t < 100 && memory_addr == 32'hFFFF_FFFC; t++) sample();
    check("wrap_addr", memory_addr, 32'h0);
    for (t = 0; t < 100 && sb.size() > 0; t++) sample();
    check("drain4", 32'(t < 100), 32'd1);

    // reset with a request outstanding, then a stray response
    step();
    lat = 6;
    sample();
    check("pre_rst_rden", 32'(memory_rden), 32'd1);
    step();
    reset = 1'b1;
    sb.delete();
    step();
    reset = 1'b0;
    stray = 1'b1;
    sample();
    check("rst2_rden", 32'(memory_rden), 32'd0);
    check("rst2_valid", 32'(instr_valid), 32'd0);
    step();
    stray = 1'b0;
    sample();
    check("rst2_valid_b", 32'(instr_valid), 32'd0);
    check("rst2_rden_b", 32'(memory_rden), 32'd1);
    check("rst2_addr", memory_addr, 32'h0);
    sb.push_back(32'h0);
    sb.push_back(32'h4);
    for (t = 0; t < 100 && sb.size() > 0; t++) sample();
    check("drain5", 32'(t < 100), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
